// File: rtl/id_stage_pkg.sv
// Shared CPU definitions: widths, instruction field positions, opcodes,
// ALU/MEM operation codes and the ID pipeline register layout.
// Latency: n/a (declarations only). Backpressure: n/a.
package id_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;

  // Instruction field positions
  localparam int OPC_W   = 6;
  localparam int OPC_LSB = 26;
  localparam int RA_LSB  = 21;
  localparam int RB_LSB  = 16;
  localparam int RC_LSB  = 11;
  localparam int IMM_W   = 16;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ANDR = 6'h00;
  localparam logic [OPC_W-1:0] OP_ANDI = 6'h01;
  localparam logic [OPC_W-1:0] OP_ORR  = 6'h02;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'h03;
  localparam logic [OPC_W-1:0] OP_ADDR = 6'h06;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'h07;
  localparam logic [OPC_W-1:0] OP_SUBR = 6'h0A;
  localparam logic [OPC_W-1:0] OP_BE   = 6'h10;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'h11;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'h14;
  localparam logic [OPC_W-1:0] OP_CALL = 6'h15;
  localparam logic [OPC_W-1:0] OP_LDW  = 6'h16;
  localparam logic [OPC_W-1:0] OP_STW  = 6'h17;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_PASS = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_e;

  // ID pipeline register; all-zero is the bubble encoding.
  typedef struct packed {
    logic [WORD_ADDR_W-1:0] pc;
    logic                   en;
    alu_op_e                alu_op;
    logic [WORD_DATA_W-1:0] alu_in0;
    logic [WORD_DATA_W-1:0] alu_in1;
    logic [REG_ADDR_W-1:0]  dst;
    logic                   we;
    mem_op_e                mem_op;
    logic [WORD_DATA_W-1:0] wr_data;
    logic                   illegal;
  } id_reg_t;

  function automatic logic [WORD_DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(WORD_DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [WORD_DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(WORD_DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational decode: fields, operand forwarding, branch resolution, load-use hazard.
// Latency: 0 cycles (pure combinational). Backpressure: Stall/Flush/LoadHazard gate BrTaken.
// Ports: IF insn/PC/valid in; GPR read addr out / data in; EX/MEM forward in;
//        BrTaken/BrAddr/LoadHazard out; dec_o = next ID register contents.
module id_decoder
  import id_stage_pkg::*;
(
  input  logic [WORD_ADDR_W-1:0] IFPC,
  input  logic [WORD_DATA_W-1:0] IFInsn,
  input  logic                   IFEn,
  input  logic                   Stall,
  input  logic                   Flush,
  output logic [REG_ADDR_W-1:0]  GprRdAddr0,
  output logic [REG_ADDR_W-1:0]  GprRdAddr1,
  input  logic [WORD_DATA_W-1:0] GprRdData0,
  input  logic [WORD_DATA_W-1:0] GprRdData1,
  input  logic [REG_ADDR_W-1:0]  ExDstAddr,
  input  logic                   ExGprWe,
  input  logic                   ExIsLoad,
  input  logic [WORD_DATA_W-1:0] ExFwdData,
  input  logic [REG_ADDR_W-1:0]  MemDstAddr,
  input  logic                   MemGprWe,
  input  logic [WORD_DATA_W-1:0] MemFwdData,
  output logic                   BrTaken,
  output logic [WORD_ADDR_W-1:0] BrAddr,
  output logic                   LoadHazard,
  output id_reg_t                dec_o
);

  logic [OPC_W-1:0]       opcode;
  logic [REG_ADDR_W-1:0]  ra, rb, rc;
  logic [IMM_W-1:0]       imm;
  logic [WORD_DATA_W-1:0] ra_val, rb_val;
  logic [WORD_ADDR_W-1:0] pc_plus1;
  logic                   rd_ra, rd_rb, br_cond;
  logic [WORD_ADDR_W-1:0] br_target;

  assign opcode   = IFInsn[OPC_LSB +: OPC_W];
  assign ra       = IFInsn[RA_LSB +: REG_ADDR_W];
  assign rb       = IFInsn[RB_LSB +: REG_ADDR_W];
  assign rc       = IFInsn[RC_LSB +: REG_ADDR_W];
  assign imm      = IFInsn[IMM_W-1:0];
  assign pc_plus1 = IFPC + 30'd1;

  assign GprRdAddr0 = ra;
  assign GprRdAddr1 = rb;

  // A load in EX has no data yet, so it never forwards; the hazard logic stalls instead.
  assign ra_val = (ExGprWe && !ExIsLoad && ExDstAddr == ra) ? ExFwdData  :
                  (MemGprWe && MemDstAddr == ra)           ? MemFwdData : GprRdData0;
  assign rb_val = (ExGprWe && !ExIsLoad && ExDstAddr == rb) ? ExFwdData  :
                  (MemGprWe && MemDstAddr == rb)           ? MemFwdData : GprRdData1;

  always_comb begin
    dec_o     = '0;
    rd_ra     = 1'b0;
    rd_rb     = 1'b0;
    br_cond   = 1'b0;
    br_target = '0;
    if (IFEn) begin
      dec_o.pc = IFPC;
      dec_o.en = 1'b1;
      case (opcode)
        OP_ANDR, OP_ORR, OP_ADDR, OP_SUBR: begin
          rd_ra         = 1'b1;
          rd_rb         = 1'b1;
          dec_o.alu_op  = (opcode == OP_ANDR) ? ALU_AND :
                          (opcode == OP_ORR)  ? ALU_OR  :
                          (opcode == OP_ADDR) ? ALU_ADD : ALU_SUB;
          dec_o.alu_in0 = ra_val;
          dec_o.alu_in1 = rb_val;
          dec_o.dst     = rc;
          dec_o.we      = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_ADDI: begin
          rd_ra         = 1'b1;
          dec_o.alu_op  = (opcode == OP_ANDI) ? ALU_AND :
                          (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
          dec_o.alu_in0 = ra_val;
          dec_o.alu_in1 = (opcode == OP_ADDI) ? sext_imm(imm) : zext_imm(imm);
          dec_o.dst     = rb;
          dec_o.we      = 1'b1;
        end
        OP_BE, OP_BNE: begin
          rd_ra     = 1'b1;
          rd_rb     = 1'b1;
          br_cond   = (opcode == OP_BE) ? (ra_val == rb_val) : (ra_val != rb_val);
          // Word-address arithmetic wraps naturally at 30 bits.
          br_target = pc_plus1 + {{(WORD_ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
        end
        OP_JMP, OP_CALL: begin
          rd_ra     = 1'b1;
          br_cond   = 1'b1;
          br_target = ra_val[WORD_DATA_W-1:2];
          if (opcode == OP_CALL) begin
            // Return byte address rides through the ALU into the link register.
            dec_o.alu_op  = ALU_PASS;
            dec_o.alu_in0 = {pc_plus1, 2'b00};
            dec_o.dst     = LINK_REG;
            dec_o.we      = 1'b1;
          end
        end
        OP_LDW: begin
          rd_ra         = 1'b1;
          dec_o.alu_op  = ALU_ADD;
          dec_o.alu_in0 = ra_val;
          dec_o.alu_in1 = sext_imm(imm);
          dec_o.dst     = rb;
          dec_o.we      = 1'b1;
          dec_o.mem_op  = MEM_READ;
        end
        OP_STW: begin
          rd_ra         = 1'b1;
          rd_rb         = 1'b1;
          dec_o.alu_op  = ALU_ADD;
          dec_o.alu_in0 = ra_val;
          dec_o.alu_in1 = sext_imm(imm);
          dec_o.mem_op  = MEM_WRITE;
          dec_o.wr_data = rb_val;
        end
        default: dec_o.illegal = 1'b1;
      endcase
    end
  end

  // Only sources the opcode actually reads can create a load-use hazard.
  assign LoadHazard = IFEn && ExIsLoad && ExGprWe &&
                      ((rd_ra && ExDstAddr == ra) || (rd_rb && ExDstAddr == rb));

  assign BrTaken = IFEn && !Stall && !Flush && !LoadHazard && br_cond;
  assign BrAddr  = BrTaken ? br_target : '0;

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: id_decoder plus the ID pipeline register.
// Latency: 1 cycle IF inputs -> ID outputs. Backpressure: Stall holds, Flush/LoadHazard insert bubble.
// Ports: clk/reset_ (sync, active-low); Stall/Flush; IF*; GPR read port; EX/MEM forward;
//        BrTaken/BrAddr/LoadHazard (combinational); ID* (registered decode results).
module id_stage
  import id_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [WORD_ADDR_W-1:0] IFPC,
  input  logic [WORD_DATA_W-1:0] IFInsn,
  input  logic                   IFEn,
  output logic [REG_ADDR_W-1:0]  GprRdAddr0,
  output logic [REG_ADDR_W-1:0]  GprRdAddr1,
  input  logic [WORD_DATA_W-1:0] GprRdData0,
  input  logic [WORD_DATA_W-1:0] GprRdData1,
  input  logic [REG_ADDR_W-1:0]  ExDstAddr,
  input  logic                   ExGprWe,
  input  logic                   ExIsLoad,
  input  logic [WORD_DATA_W-1:0] ExFwdData,
  input  logic [REG_ADDR_W-1:0]  MemDstAddr,
  input  logic                   MemGprWe,
  input  logic [WORD_DATA_W-1:0] MemFwdData,
  output logic                   BrTaken,
  output logic [WORD_ADDR_W-1:0] BrAddr,
  output logic                   LoadHazard,
  output logic [WORD_ADDR_W-1:0] IDPC,
  output logic                   IDEn,
  output logic [3:0]             IDAluOp,
  output logic [WORD_DATA_W-1:0] IDAluIn0,
  output logic [WORD_DATA_W-1:0] IDAluIn1,
  output logic [REG_ADDR_W-1:0]  IDDstAddr,
  output logic                   IDGprWe,
  output logic [1:0]             IDMemOp,
  output logic [WORD_DATA_W-1:0] IDMemWrData,
  output logic                   IDIllegal
);

  id_reg_t dec, id_d, id_q;

  id_decoder u_dec (
    .IFPC       (IFPC),
    .IFInsn     (IFInsn),
    .IFEn       (IFEn),
    .Stall      (Stall),
    .Flush      (Flush),
    .GprRdAddr0 (GprRdAddr0),
    .GprRdAddr1 (GprRdAddr1),
    .GprRdData0 (GprRdData0),
    .GprRdData1 (GprRdData1),
    .ExDstAddr  (ExDstAddr),
    .ExGprWe    (ExGprWe),
    .ExIsLoad   (ExIsLoad),
    .ExFwdData  (ExFwdData),
    .MemDstAddr (MemDstAddr),
    .MemGprWe   (MemGprWe),
    .MemFwdData (MemFwdData),
    .BrTaken    (BrTaken),
    .BrAddr     (BrAddr),
    .LoadHazard (LoadHazard),
    .dec_o      (dec)
  );

  // Flush beats Stall; Stall beats the hazard bubble. IFEn=0 already decodes to a bubble.
  always_comb begin
    id_d = id_q;
    if (Flush)           id_d = '0;
    else if (Stall)      id_d = id_q;
    else if (LoadHazard) id_d = '0;
    else                 id_d = dec;
  end

  always_ff @(posedge clk) begin
    if (!reset_) id_q <= '0;
    else         id_q <= id_d;
  end

  assign IDPC        = id_q.pc;
  assign IDEn        = id_q.en;
  assign IDAluOp     = id_q.alu_op;
  assign IDAluIn0    = id_q.alu_in0;
  assign IDAluIn1    = id_q.alu_in1;
  assign IDDstAddr   = id_q.dst;
  assign IDGprWe     = id_q.we;
  assign IDMemOp     = id_q.mem_op;
  assign IDMemWrData = id_q.wr_data;
  assign IDIllegal   = id_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID register contents are queued per step
// and compared one cycle later; combinational outputs are checked in-cycle.
module tb_id_stage;
  import id_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_, Stall, Flush, IFEn;
  logic [29:0] IFPC;
  logic [31:0] IFInsn;
  logic [4:0]  GprRdAddr0, GprRdAddr1;
  logic [31:0] GprRdData0, GprRdData1;
  logic [4:0]  ExDstAddr, MemDstAddr;
  logic        ExGprWe, ExIsLoad, MemGprWe;
  logic [31:0] ExFwdData, MemFwdData;
  logic        BrTaken, LoadHazard;
  logic [29:0] BrAddr;
  logic [29:0] IDPC;
  logic        IDEn, IDGprWe, IDIllegal;
  logic [3:0]  IDAluOp;
  logic [31:0] IDAluIn0, IDAluIn1, IDMemWrData;
  logic [4:0]  IDDstAddr;
  logic [1:0]  IDMemOp;

  logic [31:0] gpr [32];
  int n_chk  = 0;
  int n_fail = 0;
  logic [$bits(id_reg_t)-1:0] sb[$];
  logic [$bits(id_reg_t)-1:0] obs;

  always #5 clk = ~clk;

  assign GprRdData0 = gpr[GprRdAddr0];
  assign GprRdData1 = gpr[GprRdAddr1];
  assign obs = {IDPC, IDEn, IDAluOp, IDAluIn0, IDAluIn1, IDDstAddr, IDGprWe, IDMemOp, IDMemWrData, IDIllegal};

  id_stage dut (
    .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush),
    .IFPC(IFPC), .IFInsn(IFInsn), .IFEn(IFEn),
    .GprRdAddr0(GprRdAddr0), .GprRdAddr1(GprRdAddr1),
    .GprRdData0(GprRdData0), .GprRdData1(GprRdData1),
    .ExDstAddr(ExDstAddr), .ExGprWe(ExGprWe), .ExIsLoad(ExIsLoad), .ExFwdData(ExFwdData),
    .MemDstAddr(MemDstAddr), .MemGprWe(MemGprWe), .MemFwdData(MemFwdData),
    .BrTaken(BrTaken), .BrAddr(BrAddr), .LoadHazard(LoadHazard),
    .IDPC(IDPC), .IDEn(IDEn), .IDAluOp(IDAluOp), .IDAluIn0(IDAluIn0), .IDAluIn1(IDAluIn1),
    .IDDstAddr(IDDstAddr), .IDGprWe(IDGprWe), .IDMemOp(IDMemOp),
    .IDMemWrData(IDMemWrData), .IDIllegal(IDIllegal)
  );

  function automatic logic [$bits(id_reg_t)-1:0] mk(
      input logic en, input logic [29:0] pc, input alu_op_e alu,
      input logic [31:0] in0, input logic [31:0] in1, input logic [4:0] dst,
      input logic we, input mem_op_e mem, input logic [31:0] wr, input logic ill);
    id_reg_t r;
    r.pc = pc; r.en = en; r.alu_op = alu; r.alu_in0 = in0; r.alu_in1 = in1;
    r.dst = dst; r.we = we; r.mem_op = mem; r.wr_data = wr; r.illegal = ill;
    return r;
  endfunction

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
    return {op, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] a,
                                     input logic [4:0] b, input logic [15:0] im);
    return {op, a, b, im};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic drive(input logic [29:0] pc, input logic [31:0] insn, input logic en);
    IFPC = pc; IFInsn = insn; IFEn = en;
    #1;
  endtask

  // Advance one clock and compare the ID register against the oldest queued expectation.
  task automatic step(input string tag);
    logic [$bits(id_reg_t)-1:0] e;
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  logic [$bits(id_reg_t)-1:0] bub, a_reg;

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h100 + i;
    gpr[1] = 32'd5; gpr[2] = 32'd7; gpr[4] = 32'h1000_0044;
    bub = '0;
    reset_ = 1'b0; Stall = 1'b0; Flush = 1'b0;
    ExDstAddr = '0; ExGprWe = 1'b0; ExIsLoad = 1'b0; ExFwdData = '0;
    MemDstAddr = '0; MemGprWe = 1'b0; MemFwdData = '0;
    drive(30'h0, 32'h0, 1'b0);
    sb.push_back(bub); step("reset");

    // Register ALU, plain GPR operands
    reset_ = 1'b1;
    drive(30'h10, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    chk("rdaddr0", GprRdAddr0, 5'd1);
    chk("rdaddr1", GprRdAddr1, 5'd2);
    chk("no_haz", LoadHazard, 0);
    chk("no_br", BrTaken, 0);
    sb.push_back(mk(1, 30'h10, ALU_ADD, 5, 7, 3, 1, MEM_NOP, 0, 0)); step("addr_gpr");

    // EX beats MEM on the same source
    ExGprWe = 1; ExDstAddr = 5'd1; ExFwdData = 32'd9;
    MemGprWe = 1; MemDstAddr = 5'd1; MemFwdData = 32'd4;
    drive(30'h10, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(mk(1, 30'h10, ALU_ADD, 9, 7, 3, 1, MEM_NOP, 0, 0)); step("fwd_ex_wins");

    // EX on rb, MEM on ra
    ExDstAddr = 5'd2;
    drive(30'h10, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(mk(1, 30'h10, ALU_ADD, 4, 9, 3, 1, MEM_NOP, 0, 0)); step("fwd_split");

    // r0 forwards like any register
    ExGprWe = 0; MemDstAddr = 5'd0;
    drive(30'h14, rr(OP_SUBR, 5'd0, 5'd2, 5'd5), 1'b1);
    sb.push_back(mk(1, 30'h14, ALU_SUB, 4, 7, 5, 1, MEM_NOP, 0, 0)); step("fwd_r0");
    MemGprWe = 0;

    // Immediate forms: zero-extend for logic, sign-extend for ADD
    drive(30'h18, ri(OP_ORI, 5'd1, 5'd6, 16'h8001), 1'b1);
    sb.push_back(mk(1, 30'h18, ALU_OR, 5, 32'h0000_8001, 6, 1, MEM_NOP, 0, 0)); step("ori_zext");
    drive(30'h1C, ri(OP_ADDI, 5'd2, 5'd7, 16'hFFFF), 1'b1);
    sb.push_back(mk(1, 30'h1C, ALU_ADD, 7, 32'hFFFF_FFFF, 7, 1, MEM_NOP, 0, 0)); step("addi_sext");
    drive(30'h1D, ri(OP_ANDI, 5'd4, 5'd9, 16'hFF00), 1'b1);
    sb.push_back(mk(1, 30'h1D, ALU_AND, 32'h1000_0044, 32'h0000_FF00, 9, 1, MEM_NOP, 0, 0)); step("andi_zext");

    // BE taken / not taken
    gpr[2] = 32'd5;
    drive(30'h100, ri(OP_BE, 5'd1, 5'd2, 16'hFFFE), 1'b1);
    chk("be_taken", BrTaken, 1);
    chk("be_addr", BrAddr, 30'h0FF);
    sb.push_back(mk(1, 30'h100, ALU_NOP, 0, 0, 0, 0, MEM_NOP, 0, 0)); step("be_reg");
    gpr[2] = 32'd7;
    drive(30'h100, ri(OP_BE, 5'd1, 5'd2, 16'hFFFE), 1'b1);
    chk("be_not_taken", BrTaken, 0);
    chk("be_addr_zero", BrAddr, 0);
    sb.push_back(mk(1, 30'h100, ALU_NOP, 0, 0, 0, 0, MEM_NOP, 0, 0)); step("be_nt_reg");

    // BNE target wraps modulo 2^30
    drive(30'h3FFF_FFFF, ri(OP_BNE, 5'd1, 5'd2, 16'h0000), 1'b1);
    chk("bne_taken", BrTaken, 1);
    chk("bne_wrap", BrAddr, 0);
    sb.push_back(mk(1, 30'h3FFF_FFFF, ALU_NOP, 0, 0, 0, 0, MEM_NOP, 0, 0)); step("bne_reg");

    // CALL: jump to ra[31:2], link to r31
    drive(30'h20, ri(OP_CALL, 5'd4, 5'd0, 16'h0), 1'b1);
    chk("call_taken", BrTaken, 1);
    chk("call_addr", BrAddr, 30'h0400_0011);
    sb.push_back(mk(1, 30'h20, ALU_PASS, 32'h84, 0, 31, 1, MEM_NOP, 0, 0)); step("call_reg");

    // Loads and stores
    drive(30'h24, ri(OP_LDW, 5'd1, 5'd8, 16'hFFFC), 1'b1);
    sb.push_back(mk(1, 30'h24, ALU_ADD, 5, 32'hFFFF_FFFC, 8, 1, MEM_READ, 0, 0)); step("ldw");
    drive(30'h28, ri(OP_STW, 5'd1, 5'd2, 16'h0004), 1'b1);
    sb.push_back(mk(1, 30'h28, ALU_ADD, 5, 4, 0, 0, MEM_WRITE, 7, 0)); step("stw");

    // Load-use hazard
    ExIsLoad = 1; ExGprWe = 1; ExDstAddr = 5'd2; ExFwdData = 32'hDEAD;
    drive(30'h2C, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    chk("haz_rb", LoadHazard, 1);
    sb.push_back(bub); step("haz_bubble");
    drive(30'h30, ri(OP_ADDI, 5'd4, 5'd2, 16'h0001), 1'b1);
    chk("haz_imm_rb", LoadHazard, 0);
    sb.push_back(mk(1, 30'h30, ALU_ADD, 32'h1000_0044, 1, 2, 1, MEM_NOP, 0, 0)); step("haz_imm_reg");
    drive(30'h34, ri(OP_BE, 5'd2, 5'd2, 16'h0001), 1'b1);
    chk("haz_be", LoadHazard, 1);
    chk("haz_no_br", BrTaken, 0);
    sb.push_back(bub); step("haz_be_bubble");
    drive(30'h38, ri(OP_STW, 5'd1, 5'd2, 16'h0), 1'b1);
    chk("haz_stw", LoadHazard, 1);
    sb.push_back(bub); step("haz_stw_bubble");
    ExIsLoad = 0; ExGprWe = 0;

    // Stall holds everything, even with a hazard present
    a_reg = mk(1, 30'h40, ALU_ADD, 5, 7, 3, 1, MEM_NOP, 0, 0);
    drive(30'h40, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(a_reg); step("pre_stall");
    Stall = 1;
    drive(30'h44, rr(OP_ORR, 5'd1, 5'd2, 5'd4), 1'b1);
    sb.push_back(a_reg); step("stall1");
    drive(30'h48, ri(OP_JMP, 5'd4, 5'd0, 16'h0), 1'b1);
    chk("stall_no_br", BrTaken, 0);
    sb.push_back(a_reg); step("stall2");
    ExIsLoad = 1; ExGprWe = 1; ExDstAddr = 5'd1;
    drive(30'h4C, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    chk("stall_haz", LoadHazard, 1);
    sb.push_back(a_reg); step("stall3_haz");
    ExIsLoad = 0; ExGprWe = 0;

    // Flush beats Stall; Flush alone also blocks a taken branch
    Flush = 1;
    drive(30'h4C, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(bub); step("flush_stall");
    Stall = 0;
    drive(30'h4C, ri(OP_BE, 5'd1, 5'd1, 16'h0), 1'b1);
    chk("flush_no_br", BrTaken, 0);
    sb.push_back(bub); step("flush");
    Flush = 0;

    // Undefined opcode and invalid fetch
    drive(30'h50, ri(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b1);
    sb.push_back(mk(1, 30'h50, ALU_NOP, 0, 0, 0, 0, MEM_NOP, 0, 1)); step("illegal");
    drive(30'h54, ri(OP_JMP, 5'd4, 5'd0, 16'h0), 1'b0);
    chk("ifen0_no_br", BrTaken, 0);
    sb.push_back(bub); step("ifen0_bubble");

    // Reset wins over Stall and over a pending hazard
    drive(30'h60, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(mk(1, 30'h60, ALU_ADD, 5, 7, 3, 1, MEM_NOP, 0, 0)); step("pre_reset");
    Stall = 1; reset_ = 0;
    ExIsLoad = 1; ExGprWe = 1; ExDstAddr = 5'd2;
    drive(30'h64, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(bub); step("reset_stall");
    Stall = 0; reset_ = 1; ExIsLoad = 0; ExGprWe = 0;
    drive(30'h68, rr(OP_ADDR, 5'd1, 5'd2, 5'd3), 1'b1);
    sb.push_back(mk(1, 30'h68, ALU_ADD, 5, 7, 3, 1, MEM_NOP, 0, 0)); step("post_reset");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
